// File: rtl/condicionador_entradas_pkg.sv
// Shared widths, FSM state type and reset word for the input conditioner.
package condicionador_entradas_pkg;

    localparam int unsigned W_CODE = 3;
    localparam int unsigned W_FUNC = 1;
    localparam int unsigned W_BTN  = 2;
    localparam int unsigned W_WORD = W_CODE + W_FUNC + W_BTN;

    typedef logic [W_WORD-1:0] word_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    // Switches cleared, buttons released (active-low).
    localparam word_t RST_WORD = 6'b0000_11;

    function automatic word_t pack_word(input logic [W_CODE+W_FUNC-1:0] hh,
                                        input logic [W_BTN-1:0] btn);
        return {hh, btn};
    endfunction

endpackage

// File: rtl/condicionador_entradas_debounce_canal.sv
// One requester channel: 2-flop synchroniser followed by a whole-word debounce FSM.
module debounce_canal
    import condicionador_entradas_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  word_t raw,
    output word_t stable,
    output logic  chg,
    output logic  busy
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    word_t            sync1;
    word_t            s;
    word_t            cand;
    word_t            cand_nxt;
    word_t            stable_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             chg_nxt;
    state_t           state;
    state_t           state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= RST_WORD;
            s      <= RST_WORD;
            state  <= ST_IDLE;
            cand   <= RST_WORD;
            cnt    <= '0;
            stable <= RST_WORD;
            chg    <= 1'b0;
        end else begin
            sync1  <= raw;
            s      <= sync1;
            state  <= state_nxt;
            cand   <= cand_nxt;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
            chg    <= chg_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        chg_nxt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (s != stable) begin
                    cand_nxt  = s;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (s != cand) begin
                    // A return to the accepted word is a bounce; anything else restarts the count.
                    if (s == stable) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cand_nxt = s;
                        cnt_nxt  = CNT_W'(1);
                    end
                end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    stable_nxt = cand;
                    chg_nxt    = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == ST_CHECK);

endmodule

// File: rtl/condicionador_entradas.sv
// Input conditioner: two independent debounced requester channels feeding the access-control core.
module condicionador_entradas
    import condicionador_entradas_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] HH0_RAW,
    input  logic [1:0] B0_RAW,
    input  logic [3:0] HH1_RAW,
    input  logic [1:0] B1_RAW,
    output logic [3:0] HH0,
    output logic [1:0] B0,
    output logic [3:0] HH1,
    output logic [1:0] B1,
    output logic       CHG0,
    output logic       CHG1,
    output logic       BUSY
);

    word_t word0_raw;
    word_t word1_raw;
    word_t word0;
    word_t word1;
    logic  busy0;
    logic  busy1;

    assign word0_raw = pack_word(HH0_RAW, B0_RAW);
    assign word1_raw = pack_word(HH1_RAW, B1_RAW);

    debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) u_canal0 (
        .clk    (CLK),
        .rst    (RST),
        .raw    (word0_raw),
        .stable (word0),
        .chg    (CHG0),
        .busy   (busy0)
    );

    debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) u_canal1 (
        .clk    (CLK),
        .rst    (RST),
        .raw    (word1_raw),
        .stable (word1),
        .chg    (CHG1),
        .busy   (busy1)
    );

    assign HH0  = word0[W_WORD-1:W_BTN];
    assign B0   = word0[W_BTN-1:0];
    assign HH1  = word1[W_WORD-1:W_BTN];
    assign B1   = word1[W_BTN-1:0];
    assign BUSY = busy0 | busy1;

endmodule
